// File: rtl/alu_cmd_master_if.sv
// Request, uart_tx and uart_rx signals of alu_cmd_master bundled as one interface.
// The master modport is the block's view; slave is the peer/bench view.
interface alu_cmd_master_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic               i_req_valid;
  logic               o_req_ready;
  logic [NB_DATA-1:0] i_datoA;
  logic [NB_DATA-1:0] i_datoB;
  logic [NB_OP-1:0]   i_operation;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    input  i_req_valid, i_datoA, i_datoB, i_operation, i_tx_done, i_rx_data, i_rx_done,
    output o_req_ready, o_tx_start, o_tx_data, o_result, o_result_valid, o_busy, o_timeout
  );

  modport slave (
    output i_req_valid, i_datoA, i_datoB, i_operation, i_tx_done, i_rx_data, i_rx_done,
    input  o_req_ready, o_tx_start, o_tx_data, o_result, o_result_valid, o_busy, o_timeout
  );
endinterface

// File: rtl/alu_cmd_master.sv
// Host-side UART ALU initiator: sends A, B, opcode bytes, then waits for the result byte.
// Optional response timeout enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_master #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input logic              clk,
  input logic              i_rst_n,
  alu_cmd_master_if.master bus
);

  if (NB_OP > NB_DATA || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("alu_cmd_master: need NB_OP <= NB_DATA and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSendA,
    StWaitA,
    StSendB,
    StWaitB,
    StSendOp,
    StWaitOp,
    StWaitRes
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               timeout_pulse;
  logic               req_ready;
  logic [NB_DATA-1:0] op_byte;

  assign op_byte = NB_DATA'(op_q);

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int unsigned      CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign timeout_pulse = timeout_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  // Ready stays low during the result/timeout pulse cycle to force one idle gap.
  assign req_ready = (state_q == StIdle) && !valid_q && !timeout_pulse;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef ALU_CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
    timeout_d = 1'b0;
    // Held at zero outside WAIT_RES, so it starts from zero on every entry.
    cnt_d     = (state_q == StWaitRes) ? cnt_q + CntW'(1) : '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.i_req_valid && req_ready) begin
          a_d     = bus.i_datoA;
          b_d     = bus.i_datoB;
          op_d    = bus.i_operation;
          state_d = StSendA;
        end
      end
      StSendA:  state_d = StWaitA;
      StWaitA:  if (bus.i_tx_done) state_d = StSendB;
      StSendB:  state_d = StWaitB;
      StWaitB:  if (bus.i_tx_done) state_d = StSendOp;
      StSendOp: state_d = StWaitOp;
      StWaitOp: if (bus.i_tx_done) state_d = StWaitRes;
      StWaitRes: begin
        // A result byte on the terminal-count cycle takes priority over the timeout.
        if (bus.i_rx_done) begin
          result_d = bus.i_rx_data;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
`ifdef ALU_CMD_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.o_tx_data = '0;
    unique case (state_q)
      StSendA, StWaitA:   bus.o_tx_data = a_q;
      StSendB, StWaitB:   bus.o_tx_data = b_q;
      StSendOp, StWaitOp: bus.o_tx_data = op_byte;
      default:            bus.o_tx_data = '0;
    endcase
  end

  assign bus.o_tx_start     = (state_q == StSendA) || (state_q == StSendB) ||
                              (state_q == StSendOp);
  assign bus.o_req_ready    = req_ready;
  assign bus.o_busy         = (state_q != StIdle);
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = valid_q;
  assign bus.o_timeout      = timeout_pulse;

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
Host-side initiator for the UART ALU command protocol. It accepts one operation request (operand A, operand B, opcode) and drives a uart_tx instance to send three bytes. It then waits for the one-byte result from a uart_rx instance and returns that result on a valid pulse. The block sits opposite uart_interface, on a second FPGA or in a loopback bench, and connects to its own uart_tx, uart_rx and baudrate_generator.

Parameters:
NB_DATA, 8, UART byte width and operand/result width
NB_OP, 6, opcode width; zero-extended to NB_DATA on the wire (NB_OP <= NB_DATA)
TIMEOUT_CYCLES, 2_000_000, clk cycles allowed between the last tx_done and the result byte (used only with the optional feature)

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  block can accept a request (high only in IDLE)
i_datoA  in  NB_DATA  operand A
i_datoB  in  NB_DATA  operand B
i_operation  in  NB_OP  opcode
o_tx_start  out  1  one-cycle start pulse to uart_tx
o_tx_data  out  NB_DATA  byte to uart_tx; held stable from the start pulse until tx_done
i_tx_done  in  1  uart_tx byte-complete pulse
i_rx_data  in  NB_DATA  byte from uart_rx
i_rx_done  in  1  uart_rx byte-valid pulse
o_result  out  NB_DATA  captured result
o_result_valid  out  1  one-cycle pulse: o_result is new
o_busy  out  1  high in every state except IDLE
o_timeout  out  1  one-cycle pulse on a response timeout (tied 0 without the feature)

Behaviour:
- Reset (asynchronous, i_rst_n=0): state=IDLE. All outputs 0 except o_req_ready=1. Internal A/B/op registers and the counter are cleared.
- Reset mid-transaction aborts immediately. No result or timeout pulse is issued. An in-flight UART byte is not this block's concern.
- Request accept: handshake when i_req_valid & o_req_ready on a rising edge. A, B and op are latched; later input changes are ignored.
- FSM: IDLE -> SEND_A -> WAIT_A -> SEND_B -> WAIT_B -> SEND_OP -> WAIT_OP -> WAIT_RES -> IDLE.
- SEND_x (one cycle each):
  - o_tx_data <= byte; o_tx_start=1 for exactly this cycle; go to WAIT_x.
  - Wire byte order is A, then B, then {(NB_DATA-NB_OP)'b0, op}.
- WAIT_x: hold o_tx_data; stay until i_tx_done=1, then take the next SEND state (or WAIT_RES after WAIT_OP).
- Latency:
  - o_tx_start pulses 1 cycle after accept.
  - Each later o_tx_start pulses 1 cycle after the previous i_tx_done.
- i_rx_done outside WAIT_RES is ignored (stale or echo bytes are dropped).
- WAIT_RES: on i_rx_done, o_result <= i_rx_data; o_result_valid=1 on the next cycle; state -> IDLE on that same edge.
- o_result holds its value until the next capture.
- o_req_ready is asserted in IDLE the cycle after o_result_valid. Back-to-back requests are therefore spaced at least 1 idle cycle apart.
- i_tx_done arriving in the same cycle as the state's own start pulse (SEND_x) is ignored; only WAIT_x consumes it.
- i_rx_done and i_tx_done together in WAIT_OP: tx_done is honoured, rx_done is dropped.

Optional Feature:
Macro: ALU_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RES and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done: o_timeout pulses 1 cycle, o_result is unchanged, no result-valid pulse, state -> IDLE.
  - i_rx_done on the terminal-count cycle wins: the result is captured and no timeout is raised.
- Not defined: no counter; WAIT_RES waits indefinitely; o_timeout is constant 0.

Test Plan:
1. Reset with i_rst_n=0 -> o_req_ready=1, o_busy=0, o_tx_start=0, o_result=0, o_timeout=0.
2. Request A=0x12, B=0x34, op=6'h20; bench returns i_tx_done 5 cycles after each start and i_rx_done with 0x46 -> bytes 0x12, 0x34, 0x20 in order, exactly 3 start pulses, o_result=0x46 with a single 1-cycle valid, then IDLE.
3. Change i_datoA to 0xFF during WAIT_A, and pulse i_rx_done=0xAA during WAIT_B -> wire bytes unchanged; 0xAA is ignored; final result comes only from the WAIT_RES byte.
4. Deassert i_rst_n during WAIT_B -> immediate IDLE, no further start pulses, no valid pulse; a fresh request afterwards begins again with byte A.
5. With ALU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, no i_rx_done -> o_timeout pulses 100 cycles after entering WAIT_RES, o_result keeps its prior value, o_req_ready=1 on the next cycle.
6. With ALU_CMD_TIMEOUT_EN, i_rx_done=0x07 on the terminal-count cycle -> o_result=0x07 with a valid pulse, o_timeout stays 0.
